// File: rtl/goto_rep_checker.sv
// Hardware monitor for "trig_i rise, one idle cycle, MIN..MAX evt_i hits, then done_i".
// Define GOTO_TIMEOUT_EN to fail evaluations that stall for TIMEOUT cycles in CNT/CHK.
module goto_rep_checker #(
  parameter int MIN_HITS = 2,
  parameter int MAX_HITS = 4,
  parameter int CNT_W    = 3,
  parameter int TALLY_W  = 8,
  parameter int TIMEOUT  = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               trig_i,
  input  logic               evt_i,
  input  logic               done_i,
  output logic               busy,
  output logic [CNT_W-1:0]   hit_cnt,
  output logic               pass,
  output logic               fail,
  output logic               overlap,
  output logic [TALLY_W-1:0] pass_tally,
  output logic [TALLY_W-1:0] fail_tally
);

  typedef enum logic [1:0] {IDLE, DLY, CNT, CHK} state_t;

  localparam logic [CNT_W-1:0]   MIN_C   = CNT_W'(MIN_HITS);
  localparam logic [CNT_W-1:0]   MAX_C   = CNT_W'(MAX_HITS);
  localparam logic [TALLY_W-1:0] TALLY_MAX = {TALLY_W{1'b1}};

  state_t           state;
  state_t           state_nx;
  logic             trig_q;
  logic             rose;
  logic [CNT_W-1:0] hit_nx;
  logic [CNT_W-1:0] hit_inc;
  logic             pass_hit;
  logic             fail_hit;
  logic             decide;
  logic             overlap_nx;
  logic             defer_nx;
  logic             defer_q;

  assign rose    = trig_i & ~trig_q;
  assign hit_inc = hit_cnt + 1'b1;

`ifdef GOTO_TIMEOUT_EN
  localparam int             TMO_W    = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  logic [TMO_W-1:0] tmo_cnt;
  logic             tmo_hit;

  // Entry to DLY is always from IDLE, so clearing in IDLE restarts the count per evaluation.
  always_ff @(posedge clk) begin
    if (!rst_n)
      tmo_cnt <= '0;
    else if (state == IDLE)
      tmo_cnt <= '0;
    else if (state == CNT || state == CHK)
      tmo_cnt <= tmo_cnt + 1'b1;
  end

  assign tmo_hit = (state == CNT || state == CHK) && (tmo_cnt == TMO_LAST);
`endif

  always_ff @(posedge clk) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    hit_nx   = hit_cnt;
    pass_hit = 1'b0;
    fail_hit = 1'b0;
    unique case (state)
      IDLE: begin
        hit_nx = '0;
        if (rose)
          state_nx = DLY;
      end
      DLY: state_nx = CNT;
      CNT: begin
        if (evt_i) begin
          hit_nx = hit_inc;
          if (hit_inc >= MIN_C)
            state_nx = CHK;
        end
      end
      CHK: begin
        if (done_i) begin
          pass_hit = 1'b1;
          state_nx = IDLE;
          hit_nx   = '0;
        end else if (hit_cnt == MAX_C) begin
          fail_hit = 1'b1;
          state_nx = IDLE;
          hit_nx   = '0;
        end else if (evt_i) begin
          hit_nx = hit_inc;
        end else begin
          state_nx = CNT;
        end
      end
      default: begin
        state_nx = IDLE;
        hit_nx   = '0;
      end
    endcase
`ifdef GOTO_TIMEOUT_EN
    if (tmo_hit && !pass_hit && !fail_hit) begin
      fail_hit = 1'b1;
      state_nx = IDLE;
      hit_nx   = '0;
    end
`endif
  end

  // A rise on a deciding edge is reported one cycle later so it never coincides with pass/fail.
  always_comb begin
    busy       = (state != IDLE);
    decide     = pass_hit | fail_hit;
    overlap_nx = (rose && (state != IDLE) && !decide) || defer_q;
    defer_nx   = rose && decide;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      trig_q     <= 1'b0;
      hit_cnt    <= '0;
      pass       <= 1'b0;
      fail       <= 1'b0;
      overlap    <= 1'b0;
      defer_q    <= 1'b0;
      pass_tally <= '0;
      fail_tally <= '0;
    end else begin
      trig_q  <= trig_i;
      hit_cnt <= hit_nx;
      pass    <= pass_hit;
      fail    <= fail_hit;
      overlap <= overlap_nx;
      defer_q <= defer_nx;
      if (pass_hit && pass_tally != TALLY_MAX)
        pass_tally <= pass_tally + 1'b1;
      if (fail_hit && fail_tally != TALLY_MAX)
        fail_tally <= fail_tally + 1'b1;
    end
  end

endmodule
